// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : microcode_sequencer
// Description : Run-time writable control store that emits one registered
//               control word per micro-step, chaining via a next-address field.
// Revision    : 1.0 - initial release
// ============================================================================
module microcode_sequencer #(
    parameter int ADDR_W    = 12,
    parameter int CTRL_W    = 19,
    parameter int MAX_STEPS = 8,
    localparam int STEP_W   = $clog2(MAX_STEPS),
    localparam int W        = CTRL_W + ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_last,
    output logic              out_illegal,
    output logic              out_overrun,
    output logic [STEP_W-1:0] out_step,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_data
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // A chained read from this step lands on the final permitted step.
    localparam logic [STEP_W-1:0] c_OVR_FROM = STEP_W'(MAX_STEPS - 2);

    state_t              state_q, state_d;
    logic [W-1:0]        mem_q [2**ADDR_W];
    logic [2**ADDR_W-1:0] vld_q;

    logic                out_valid_q,   out_valid_d;
    logic [CTRL_W-1:0]   out_ctrl_q,    out_ctrl_d;
    logic                out_last_q,    out_last_d;
    logic                out_illegal_q, out_illegal_d;
    logic                out_overrun_q, out_overrun_d;
    logic [STEP_W-1:0]   out_step_q,    out_step_d;
    logic [ADDR_W-1:0]   next_q,        next_d;

    logic                w_fire;
    logic                w_accept;
    logic                w_chain;
    logic                w_ovr;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [W-1:0]        w_rd_word;
    logic                w_rd_vld;

    assign w_fire    = out_valid_q && out_ready;
    assign in_ready  = rst_n && !flush && (state_q == S_IDLE || (w_fire && out_last_q));
    assign w_accept  = in_valid && in_ready;
    assign w_chain   = !flush && w_fire && !out_last_q;
    assign w_rd_addr = w_accept ? in_addr : next_q;
    // Reads see pre-edge contents, so a same-cycle write returns the old word.
    assign w_rd_word = mem_q[w_rd_addr];
    assign w_rd_vld  = vld_q[w_rd_addr];
    assign w_ovr     = w_chain && (out_step_q == c_OVR_FROM);

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_ctrl_d    = out_ctrl_q;
        out_last_d    = out_last_q;
        out_illegal_d = out_illegal_q;
        out_overrun_d = out_overrun_q;
        out_step_d    = out_step_q;
        next_d        = next_q;
        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_step_d  = '0;
        end else if (w_accept || w_chain) begin
            state_d       = S_RUN;
            out_valid_d   = 1'b1;
            out_step_d    = w_accept ? '0 : out_step_q + STEP_W'(1);
            out_overrun_d = w_ovr;
            out_illegal_d = !w_rd_vld;
            out_ctrl_d    = w_rd_vld ? w_rd_word[CTRL_W-1:0] : '0;
            out_last_d    = !w_rd_vld || w_rd_word[W-1] || w_ovr;
            next_d        = w_rd_word[W-2:CTRL_W];
        end else if (w_fire) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            out_valid_q   <= 1'b0;
            out_ctrl_q    <= '0;
            out_last_q    <= 1'b0;
            out_illegal_q <= 1'b0;
            out_overrun_q <= 1'b0;
            out_step_q    <= '0;
            next_q        <= '0;
            vld_q         <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_ctrl_q    <= out_ctrl_d;
            out_last_q    <= out_last_d;
            out_illegal_q <= out_illegal_d;
            out_overrun_q <= out_overrun_d;
            out_step_q    <= out_step_d;
            next_q        <= next_d;
            if (wr_en) begin
                vld_q[wr_addr] <= 1'b1;
            end
        end
    end

    // Word storage is deliberately not reset; only the valid vector is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ctrl    = out_ctrl_q;
    assign out_last    = out_last_q;
    assign out_illegal = out_illegal_q;
    assign out_overrun = out_overrun_q;
    assign out_step    = out_step_q;

endmodule
`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_microcode_sequencer
// Description : Scoreboard bench for microcode_sequencer with a sequence-level
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microcode_sequencer;

    localparam int ADDR_W    = 12;
    localparam int CTRL_W    = 19;
    localparam int MAX_STEPS = 8;
    localparam int STEP_W    = 3;
    localparam int W         = 32;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_last;
    logic              out_illegal;
    logic              out_overrun;
    logic [STEP_W-1:0] out_step;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [W-1:0]      wr_data;

    microcode_sequencer #(
        .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .MAX_STEPS(MAX_STEPS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_last(out_last), .out_illegal(out_illegal), .out_overrun(out_overrun),
        .out_step(out_step),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              last;
        logic              ill;
        logic              ovr;
        logic [STEP_W-1:0] step;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] mdl_mem [4096];
    bit   [4095:0] mdl_vld;
    int           checks   = 0;
    int           failures = 0;
    bit           started  = 0;
    bit           exp_in_ready  = 0;
    bit           exp_out_valid = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mkw(input logic last, input logic [ADDR_W-1:0] nxt,
                                         input logic [CTRL_W-1:0] ctrl);
        return {last, nxt, ctrl};
    endfunction

    // Expand a whole sequence from its first word by walking the model store.
    task automatic push_seq(input logic [W-1:0] w0, input bit v0);
        logic [W-1:0] w;
        bit           v;
        exp_t         e;
        w = w0;
        v = v0;
        for (int s = 0; s < MAX_STEPS; s++) begin
            e.ovr  = (s == MAX_STEPS - 1);
            e.ill  = !v;
            e.ctrl = v ? w[CTRL_W-1:0] : '0;
            e.last = !v || w[W-1] || e.ovr;
            e.step = STEP_W'(s);
            q.push_back(e);
            if (e.last) break;
            v = mdl_vld[w[W-2:CTRL_W]];
            w = mdl_mem[w[W-2:CTRL_W]];
        end
    endtask

    // Drives one cycle of inputs (called 1 time unit after a rising edge).
    task automatic step_cyc(input bit iv, input logic [ADDR_W-1:0] ia, input bit ordy,
                            input bit fl, input bit rn, input bit we,
                            input logic [ADDR_W-1:0] wa, input logic [W-1:0] wd);
        logic [W-1:0] w0;
        bit           v0;
        bit           acc;
        exp_out_valid = (q.size() != 0);
        exp_in_ready  = rn && !fl && (q.size() == 0 || (q.size() == 1 && ordy));
        in_valid  = iv;
        in_addr   = ia;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rn;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        acc = iv && exp_in_ready;
        w0  = mdl_mem[ia];
        v0  = mdl_vld[ia];
        if (we) mdl_mem[wa] = wd;
        if (!rn) mdl_vld = '0;
        else if (we) mdl_vld[wa] = 1'b1;
        if (acc) push_seq(w0, v0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy);
        step_cyc(0, '0, ordy, 0, 1, 0, '0, '0);
    endtask

    task automatic disp(input logic [ADDR_W-1:0] a, input bit ordy);
        step_cyc(1, a, ordy, 0, 1, 0, '0, '0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
        step_cyc(0, '0, 1, 0, 1, 1, a, d);
    endtask

    // Monitor: handshake checks and scoreboard pops on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_in_ready});
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_out_valid});
            if (out_valid && q.size() > 0) begin
                chk("step_fields", {7'b0, out_ctrl, out_last, out_illegal, out_overrun, out_step},
                    {7'b0, q[0]});
                if (out_ready) void'(q.pop_front());
            end
            if (!rst_n || flush) q.delete();
        end
    end

    initial begin
        rst_n = 0; in_valid = 0; in_addr = '0; flush = 0; out_ready = 0;
        wr_en = 0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        started = 1;

        // Reset values
        step_cyc(0, '0, 0, 0, 0, 0, '0, '0);
        chk("rst_out", {6'b0, out_valid, out_ctrl, out_last, out_illegal, out_overrun, out_step}, 32'h0);
        idle(1);

        // Dispatch of an unwritten entry is illegal
        disp(12'h6E0, 1);
        chk("illegal_flags", {29'b0, out_valid, out_illegal, out_last}, 32'h7);
        chk("illegal_ctrl", {13'b0, out_ctrl}, 32'h0);
        idle(1);

        // Single-step word, three back-to-back dispatches
        wr(12'h6E0, mkw(1'b1, 12'h000, 19'h1E801));
        disp(12'h6E0, 1);
        chk("single_ctrl", {13'b0, out_ctrl}, 32'h1E801);
        disp(12'h6E0, 1);
        disp(12'h6E0, 1);
        idle(1);
        idle(1);

        // Three-step chain with a stall at step 1
        wr(12'h661, mkw(1'b0, 12'h800, 19'h1F601));
        wr(12'h800, mkw(1'b0, 12'h801, 19'h1F601));
        wr(12'h801, mkw(1'b1, 12'h000, 19'h1F601));
        disp(12'h661, 1);
        idle(1);
        repeat (3) step_cyc(1, 12'h6E0, 0, 0, 1, 0, '0, '0);
        chk("stall_step", {29'b0, out_step}, 32'd1);
        idle(1);
        idle(1);
        idle(1);

        // Self-loop runs into the step limit
        wr(12'h900, mkw(1'b0, 12'h900, 19'h00005));
        disp(12'h900, 1);
        repeat (9) idle(1);

        // Flush at step 1 with a competing dispatch
        disp(12'h661, 1);
        idle(1);
        step_cyc(1, 12'h6E0, 0, 1, 1, 0, '0, '0);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        disp(12'h661, 1);
        chk("restart_step", {29'b0, out_step}, 32'd0);
        idle(1);
        idle(1);
        idle(1);

        // Same-cycle write and dispatch returns the old word
        step_cyc(1, 12'h6E0, 1, 0, 1, 1, 12'h6E0, mkw(1'b1, 12'h000, 19'h00001));
        chk("rdw_old", {13'b0, out_ctrl}, 32'h1E801);
        disp(12'h6E0, 1);
        chk("rdw_new", {13'b0, out_ctrl}, 32'h00001);
        idle(1);

        // Reset mid-chain invalidates the store
        disp(12'h661, 1);
        idle(1);
        step_cyc(0, '0, 1, 0, 0, 0, '0, '0);
        chk("midrst_out", {6'b0, out_valid, out_ctrl, out_last, out_illegal, out_overrun, out_step}, 32'h0);
        disp(12'h6E0, 1);
        chk("midrst_illegal", {31'b0, out_illegal}, 32'd1);
        idle(1);

        // Random traffic over a small address pool
        for (int i = 0; i < 800; i++) begin
            bit                iv, ordy, fl, rn, we;
            logic [ADDR_W-1:0] ia, wa, nx;
            logic [CTRL_W-1:0] cw;
            iv   = ($urandom % 2) == 0;
            ia   = 12'hA00 | ADDR_W'($urandom % 16);
            ordy = ($urandom % 4) != 0;
            fl   = ($urandom % 40) == 0;
            rn   = ($urandom % 150) != 0;
            we   = rn && (q.size() == 0) && (($urandom % 3) == 0);
            wa   = 12'hA00 | ADDR_W'($urandom % 16);
            nx   = 12'hA00 | ADDR_W'($urandom % 16);
            cw   = CTRL_W'($urandom);
            step_cyc(iv, ia, ordy, fl, rn, we, wa, mkw(1'(($urandom % 2)), nx, cw));
        end

        repeat (12) idle(1);
        chk("drained", q.size(), 32'd0);
        started = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
